// File: rtl/dist_mem_arbiter.sv
// dist_mem_arbiter: round-robin arbiter sharing one single-port distributed RAM
// (sync write, async read) between two requesters, with registered read data.
// Optional init sweep enabled by defining MEM_INIT_SWEEP_EN: after reset every
// word is written with INIT_VAL before any request is accepted.
module dist_mem_arbiter #(
   parameter int unsigned   AW       = 4,
   parameter int unsigned   DW       = 2,
   parameter logic [DW-1:0] INIT_VAL = '0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req0_i,
   input  logic          req1_i,
   input  logic          we0_i,
   input  logic          we1_i,
   input  logic [AW-1:0] addr0_i,
   input  logic [AW-1:0] addr1_i,
   input  logic [DW-1:0] wdata0_i,
   input  logic [DW-1:0] wdata1_i,
   output logic          ack0_o,
   output logic          ack1_o,
   output logic          rvalid0_o,
   output logic          rvalid1_o,
   output logic [DW-1:0] rdata0_o,
   output logic [DW-1:0] rdata1_o,
   output logic          init_done_o,
   output logic [AW-1:0] mem_a_o,
   output logic [DW-1:0] mem_d_o,
   output logic          mem_we_o,
   input  logic [DW-1:0] mem_spo_i
);

   logic          run;
   logic          sweep_en;
   logic [AW-1:0] sweep_a;

   logic          prio_q;
   logic [AW-1:0] last_a_q;
   logic [DW-1:0] last_d_q;
   logic          rvalid0_q;
   logic          rvalid1_q;
   logic [DW-1:0] rdata0_q;
   logic [DW-1:0] rdata1_q;

   logic          gnt_valid;
   logic          gnt_idx;
   logic          gnt_we;
   logic [AW-1:0] gnt_a;
   logic [DW-1:0] gnt_d;

`ifdef MEM_INIT_SWEEP_EN
   typedef enum logic {StSweep, StRun} state_e;

   state_e        state_q;
   logic [AW-1:0] sweep_a_q;
   logic          init_done_q;

   // Sweep FSM: one word per cycle from address 0, then RUN until the next reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StSweep;
         sweep_a_q   <= '0;
         init_done_q <= 1'b0;
      end else if (state_q == StSweep) begin
         sweep_a_q <= sweep_a_q + AW'(1);
         if (sweep_a_q == {AW{1'b1}}) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
         end
      end
   end

   // Reset masks both the sweep write and any grant in the reset cycle.
   assign run         = (state_q == StRun) & ~rst_i;
   assign sweep_en    = (state_q == StSweep) & ~rst_i;
   assign sweep_a     = sweep_a_q;
   assign init_done_o = init_done_q;
`else
   assign run         = ~rst_i;
   assign sweep_en    = 1'b0;
   assign sweep_a     = '0;
   assign init_done_o = 1'b1;
`endif

   // Winner: a lone requester always wins; on contention the prio bit decides.
   assign gnt_valid = run & (req0_i | req1_i);
   assign gnt_idx   = (req0_i & req1_i) ? prio_q : req1_i;
   assign gnt_we    = gnt_idx ? we1_i    : we0_i;
   assign gnt_a     = gnt_idx ? addr1_i  : addr0_i;
   assign gnt_d     = gnt_idx ? wdata1_i : wdata0_i;

   assign ack0_o = gnt_valid & ~gnt_idx;
   assign ack1_o = gnt_valid & gnt_idx;

   // RAM port mux: sweep, then granted command, else hold last granted address/data.
   always_comb begin
      mem_we_o = 1'b0;
      mem_a_o  = last_a_q;
      mem_d_o  = last_d_q;
      if (sweep_en) begin
         mem_we_o = 1'b1;
         mem_a_o  = sweep_a;
         mem_d_o  = INIT_VAL;
      end else if (gnt_valid) begin
         mem_we_o = gnt_we;
         mem_a_o  = gnt_a;
         mem_d_o  = gnt_d;
      end
   end

   // Priority rotation, read-data capture and one-cycle rvalid pulses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q    <= 1'b0;
         last_a_q  <= '0;
         last_d_q  <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         rvalid0_q <= ack0_o & ~we0_i;
         rvalid1_q <= ack1_o & ~we1_i;
         if (ack0_o & ~we0_i) rdata0_q <= mem_spo_i;
         if (ack1_o & ~we1_i) rdata1_q <= mem_spo_i;
         if (gnt_valid) begin
            prio_q   <= ~gnt_idx;
            last_a_q <= gnt_a;
            last_d_q <= gnt_d;
         end
      end
   end

   // A pending rvalid is dropped as soon as reset is seen, not one edge later.
   assign rvalid0_o = rvalid0_q & ~rst_i;
   assign rvalid1_o = rvalid1_q & ~rst_i;
   assign rdata0_o  = rdata0_q;
   assign rdata1_o  = rdata1_q;

endmodule

// File: tb/tb_dist_mem_arbiter.sv
// Bench for dist_mem_arbiter: directed scenarios plus random traffic, checked
// against a cycle-level reference model (memory array, prio bit, read pipeline).
module tb_dist_mem_arbiter;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 2;
   localparam logic [DW-1:0] INIT = 2'd1;
`ifdef MEM_INIT_SWEEP_EN
   localparam bit SWEEP = 1'b1;
`else
   localparam bit SWEEP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1, rvalid0, rvalid1, init_done, mem_we;
   logic [DW-1:0] rdata0, rdata1, mem_d, mem_spo;
   logic [AW-1:0] mem_a;

   // RAM core stand-in: synchronous write, asynchronous read.
   logic [DW-1:0] ram [16] = '{default: '0};
   always @(posedge clk) if (mem_we) ram[mem_a] <= mem_d;
   assign mem_spo = ram[mem_a];

   always #5 clk = ~clk;

   dist_mem_arbiter #(.AW(AW), .DW(DW), .INIT_VAL(INIT)) dut (
      .clk_i(clk), .rst_i(rst),
      .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
      .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
      .ack0_o(ack0), .ack1_o(ack1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
      .rdata0_o(rdata0), .rdata1_o(rdata1), .init_done_o(init_done),
      .mem_a_o(mem_a), .mem_d_o(mem_d), .mem_we_o(mem_we), .mem_spo_i(mem_spo)
   );

   // Reference model state
   logic [DW-1:0] exp_mem [16] = '{default: '0};
   bit            exp_prio;
   bit            exp_rv0, exp_rv1;
   logic [DW-1:0] exp_rd0, exp_rd1;

   int tests = 0;
   int fails = 0;
   bit gg0, gg1, p0, p1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set0(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
   endtask

   task automatic set1(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
   endtask

   // One RUN cycle; called at a negedge with inputs already driven.
   task automatic step(output bit g0, output bit g1);
      #2;
      g0 = req0 && (!req1 || !exp_prio);
      g1 = req1 && (!req0 || exp_prio);
      check("ack0", ack0, g0);
      check("ack1", ack1, g1);
      check("init_done_run", init_done, 1);
      if (g0) begin
         check("mem_we_p0", mem_we, we0);
         check("mem_a_p0", mem_a, addr0);
         if (we0) check("mem_d_p0", mem_d, wdata0);
      end
      if (g1) begin
         check("mem_we_p1", mem_we, we1);
         check("mem_a_p1", mem_a, addr1);
         if (we1) check("mem_d_p1", mem_d, wdata1);
      end
      if (!g0 && !g1) check("mem_we_idle", mem_we, 0);
      @(posedge clk);
      exp_rv0 = 1'b0;
      exp_rv1 = 1'b0;
      if (g0) begin
         if (we0) exp_mem[addr0] = wdata0;
         else begin exp_rd0 = exp_mem[addr0]; exp_rv0 = 1'b1; end
         exp_prio = 1'b1;
      end
      if (g1) begin
         if (we1) exp_mem[addr1] = wdata1;
         else begin exp_rd1 = exp_mem[addr1]; exp_rv1 = 1'b1; end
         exp_prio = 1'b0;
      end
      #1;
      check("rvalid0", rvalid0, exp_rv0);
      check("rvalid1", rvalid1, exp_rv1);
      check("rdata0", rdata0, exp_rd0);
      check("rdata1", rdata1, exp_rd1);
      @(negedge clk);
   endtask

   // One-cycle reset, then sweep_len sweep cycles when the sweep is built in.
   task automatic do_reset(input int sweep_len);
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      #2;
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
      check("rst_rvalid0_drop", rvalid0, 0);
      check("rst_rvalid1_drop", rvalid1, 0);
      check("rst_mem_we", mem_we, 0);
      @(posedge clk);
      #1;
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      check("rst_rvalid0", rvalid0, 0);
      check("rst_rvalid1", rvalid1, 0);
      check("rst_mem_a", mem_a, 0);
      check("rst_mem_d", mem_d, 0);
      check("rst_init_done", init_done, !SWEEP);
      exp_prio = 1'b0; exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rd0 = '0; exp_rd1 = '0;
      @(negedge clk);
      rst = 1'b0;
`ifdef MEM_INIT_SWEEP_EN
      set0(1'b1, 1'b0, 4'd9, 2'd0);
      set1(1'b1, 1'b1, 4'd10, 2'd3);
      for (int i = 0; i < sweep_len; i++) begin
         #2;
         check("sweep_init_done", init_done, 0);
         check("sweep_ack0", ack0, 0);
         check("sweep_ack1", ack1, 0);
         check("sweep_we", mem_we, 1);
         check("sweep_a", mem_a, i);
         check("sweep_d", mem_d, INIT);
         exp_mem[i] = INIT;
         @(negedge clk);
      end
      req0 = 1'b0; req1 = 1'b0;
`else
      if (sweep_len < 0) $display("[TB] unexpected sweep length");
`endif
   endtask

   initial begin
      set0(1'b0, 1'b0, '0, '0);
      set1(1'b0, 1'b0, '0, '0);
      do_reset(16);

      // Write then read back on port 0
      set0(1'b1, 1'b1, 4'd3, 2'd2); step(gg0, gg1);
      set0(1'b1, 1'b0, 4'd3, 2'd0); step(gg0, gg1);
      check("t1_rvalid0", rvalid0, 1);
      check("t1_rdata0", rdata0, 2);
      req0 = 1'b0; step(gg0, gg1);

      // Contended write wins first, losing read sees the new data
      do_reset(16);
      set0(1'b1, 1'b1, 4'd5, 2'd3);
      set1(1'b1, 1'b0, 4'd5, 2'd0);
      step(gg0, gg1);
      req0 = 1'b0; step(gg0, gg1);
      check("t6_rdata1", rdata1, 3);

      // Continuous dual request alternates starting with port 0
      do_reset(16);
      set0(1'b1, 1'b0, 4'd1, 2'd0);
      set1(1'b1, 1'b0, 4'd2, 2'd0);
      for (int k = 0; k < 6; k++) step(gg0, gg1);

      // Port 1 alone, then both: port 0 wins the contention
      do_reset(16);
      set1(1'b1, 1'b0, 4'd4, 2'd0); step(gg0, gg1);
      set0(1'b1, 1'b0, 4'd6, 2'd0); step(gg0, gg1);
      check("t3_ack0_won", gg0, 1);
      req0 = 1'b0; step(gg0, gg1);
      req1 = 1'b0; step(gg0, gg1);

      // Reset right after a read ack drops the rvalid and restores prio
      set0(1'b1, 1'b0, 4'd3, 2'd0); step(gg0, gg1);
      do_reset(16);
      set0(1'b1, 1'b0, 4'd0, 2'd0);
      set1(1'b1, 1'b0, 4'd1, 2'd0);
      step(gg0, gg1);
      req0 = 1'b0; req1 = 1'b0;

      // Read every word (sweep contents when built in)
      for (int a = 0; a < 16; a++) begin
         set0(1'b1, 1'b0, 4'(a), 2'd0);
         step(gg0, gg1);
      end
      req0 = 1'b0; step(gg0, gg1);

      // Reset mid-sweep restarts from address 0
      do_reset(7);
      do_reset(16);
      for (int a = 0; a < 16; a++) begin
         set1(1'b1, 1'b0, 4'(a), 2'd0);
         step(gg0, gg1);
      end
      req1 = 1'b0;

      // Random traffic; commands held stable until acked
      p0 = 1'b0; p1 = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!p0) begin
            if ($urandom_range(0, 2) != 0) begin
               set0(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)));
               p0 = 1'b1;
            end else req0 = 1'b0;
         end
         if (!p1) begin
            if ($urandom_range(0, 2) != 0) begin
               set1(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)));
               p1 = 1'b1;
            end else req1 = 1'b0;
         end
         step(gg0, gg1);
         if (gg0) p0 = 1'b0;
         if (gg1) p1 = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
